// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: synchronises one raw pushbutton pin to clk and filters
// contact bounce with a counter FSM. A change is accepted only after the
// synchronised key has been stable in its new state for DEB_CYCLES cycles.
// The block produces a clean debounced level plus single-cycle press/release
// pulses, so the downstream flop stage never sees bounce edges.
//
// Ports:
//   clk          in  system clock, rising edge
//   rst          in  synchronous reset, active-high
//   key_in       in  raw asynchronous pushbutton pin
//   key_level    out debounced level, 1 = pressed
//   key_press    out one-cycle pulse on each accepted press
//   key_release  out one-cycle pulse on each accepted release
//   busy         out high while a change is being qualified
module key_debounce_pulse #(
  parameter int unsigned DEB_CYCLES     = 1000000,
  parameter int unsigned CNT_W          = 20,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic busy
);

  // Pin level seen while the key is released.
  localparam logic RELEASED = KEY_ACTIVE_LOW;
  // Final counter value of a qualification window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic             s1;
  logic             s2;
  logic             kp;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_d;
  logic             release_d;
  logic             level_d;
  logic             busy_d;

  // Two-flop synchroniser; reset parks it at the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RELEASED;
      s2 <= RELEASED;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  // Normalised key: 1 = pressed regardless of pin polarity.
  assign kp = s2 ^ RELEASED;

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
      busy        <= busy_d;
    end
  end

  // Next-state and next-output logic; outputs track the next state so the
  // registered values line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (kp) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!kp) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!kp) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (kp) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    busy_d  = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
  end

endmodule
